// File: rtl/spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// spi_slave_ctrl
// SPI slave front-end for the single-port RAM. A frame is one SS_n-low
// interval. MOSI is sampled MSB first on clk and assembled into a
// {cmd[1:0], payload[MEM_WIDTH-1:0]} word on rx_data with a one-cycle rx_valid
// pulse. After a read-data frame the RAM's tx_data is shifted out on MISO,
// MSB first.
//
// Ports
//   clk        system clock, all logic on posedge; SS_n/MOSI sampled on it
//   rst_n      asynchronous active-low reset
//   SS_n       slave select, active low
//   MOSI       serial data in
//   MISO       serial data out (registered, 0 when not shifting read data)
//   rx_data    received word, valid while rx_valid=1, held between pulses
//   rx_valid   one-cycle pulse per completed frame
//   tx_data    RAM read data
//   tx_valid   tx_data valid, accepted only while waiting after a read-data frame
//   frame_err  (SPI_SLAVE_FRAME_ERR_EN only) one-cycle pulse when a frame or a
//              read-data transfer is cut short by SS_n rising
//
// Build option: define SPI_SLAVE_FRAME_ERR_EN to add the frame_err output.
// -----------------------------------------------------------------------------
module spi_slave_ctrl #(
  parameter int MEM_WIDTH = 8,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [MEM_WIDTH+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [MEM_WIDTH-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  // state        | meaning
  // ST_IDLE      | no frame, waiting for SS_n low
  // ST_CHK_CMD   | sampling the first command bit to pick the frame type
  // ST_WRITE     | receiving a write-address / write-data frame
  // ST_READ_ADD  | receiving a read-address frame
  // ST_READ_DATA | receiving a read-data frame, then waiting for / shifting tx_data
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK_CMD,
    ST_WRITE,
    ST_READ_ADD,
    ST_READ_DATA
  } state_t;

  localparam int FRAME_BITS = MEM_WIDTH + 2;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int TX_CNT_W   = $clog2(MEM_WIDTH + 1);
  localparam logic [CNT_W-1:0]    LP_FRAME   = CNT_W'(FRAME_BITS);
  localparam logic [TX_CNT_W-1:0] LP_TX_LAST = TX_CNT_W'(MEM_WIDTH - 1);

  // The payload field doubles as the RAM address, so the address cannot be
  // wider than one data word.
  if (ADDR_SIZE > MEM_WIDTH) begin : g_addr_wider_than_payload
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_done;       // frame word already delivered
  logic                  r_rd_addr_seen;
  logic                  r_tx_wait;
  logic                  r_tx_busy;
  logic [MEM_WIDTH-1:0]  r_tx_shift;
  logic [TX_CNT_W-1:0]   r_tx_cnt;     // MISO bits still to send after the current one
  logic                  r_miso;
  logic [FRAME_BITS-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  w_abort;
  logic                  w_data_state;

  assign w_abort      = (r_state != ST_IDLE) && SS_n;
  assign w_data_state = (r_state == ST_WRITE) || (r_state == ST_READ_ADD) ||
                        (r_state == ST_READ_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (!SS_n) w_state_nxt = ST_CHK_CMD;
      ST_CHK_CMD: begin
        if (SS_n)                w_state_nxt = ST_IDLE;
        else if (!MOSI)          w_state_nxt = ST_WRITE;
        else if (r_rd_addr_seen) w_state_nxt = ST_READ_DATA;
        else                     w_state_nxt = ST_READ_ADD;
      end
      default:    if (SS_n) w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_done         <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_tx_wait      <= 1'b0;
      r_tx_busy      <= 1'b0;
      r_tx_shift     <= '0;
      r_tx_cnt       <= '0;
      r_miso         <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_abort) begin
        // SS_n wins over everything, including a bit due this cycle.
        r_bit_cnt <= '0;
        r_done    <= 1'b0;
        r_tx_wait <= 1'b0;
        r_tx_busy <= 1'b0;
        r_tx_cnt  <= '0;
        r_miso    <= 1'b0;
      end else if (r_state == ST_CHK_CMD) begin
        r_shift   <= {r_shift[FRAME_BITS-2:0], MOSI};
        r_bit_cnt <= CNT_W'(1);
        r_done    <= 1'b0;
      end else if (w_data_state) begin
        if (r_bit_cnt < LP_FRAME) begin
          r_shift   <= {r_shift[FRAME_BITS-2:0], MOSI};
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end else if (!r_done) begin
          r_done     <= 1'b1;
          r_rx_valid <= 1'b1;
          r_rx_data  <= r_shift;
          if (r_state == ST_READ_ADD)  r_rd_addr_seen <= 1'b1;
          if (r_state == ST_READ_DATA) r_tx_wait      <= 1'b1;
        end else if (r_state == ST_READ_DATA) begin
          if (r_tx_wait && tx_valid) begin
            r_tx_wait  <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_miso     <= tx_data[MEM_WIDTH-1];
            r_tx_shift <= {tx_data[MEM_WIDTH-2:0], 1'b0};
            r_tx_cnt   <= LP_TX_LAST;
          end else if (r_tx_busy) begin
            if (r_tx_cnt != '0) begin
              r_miso     <= r_tx_shift[MEM_WIDTH-1];
              r_tx_shift <= {r_tx_shift[MEM_WIDTH-2:0], 1'b0};
              r_tx_cnt   <= r_tx_cnt - TX_CNT_W'(1);
            end else begin
              r_miso         <= 1'b0;
              r_tx_busy      <= 1'b0;
              r_rd_addr_seen <= 1'b0;
            end
          end
        end
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic r_frame_err;
  logic w_partial;

  // A complete word awaiting its rx_valid pulse is not a partial frame.
  assign w_partial = (w_data_state && (r_bit_cnt < LP_FRAME)) ||
                     ((r_state == ST_READ_DATA) && (r_tx_wait || r_tx_busy));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_err <= 1'b0;
    else        r_frame_err <= w_abort && w_partial;
  end

  assign frame_err = r_frame_err;
`endif

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
module tb_spi_slave_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err;
  int         n_ferr = 0;
`endif

  spi_slave_ctrl #(.MEM_WIDTH(8), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] data;
    int         cyc;
  } rx_exp_t;

  rx_exp_t    rx_q[$];
  logic [7:0] tx_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // rx scoreboard: every rx_valid must match the next expected word and time
  initial begin
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rx_valid === 1'b1) begin
        if (rx_q.size() == 0) begin
          chk("rx_unexpected_pulse", {22'h0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          e = rx_q.pop_front();
          chk("rx_data", {22'h0, rx_data}, {22'h0, e.data});
          chk("rx_latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // MISO scoreboard: an accepted tx_valid yields 8 MISO bits then 0
  initial begin
    logic [7:0] exp_b, got;
    forever begin
      @(posedge clk);
      if (tx_valid === 1'b1 && tx_q.size() != 0) begin
        exp_b = tx_q.pop_front();
        got   = 8'h00;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          got = {got[6:0], MISO};
        end
        chk("miso_byte", {24'h0, got}, {24'h0, exp_b});
        @(negedge clk);
        chk("miso_after_last", {31'h0, MISO}, 32'h0);
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  always @(negedge clk) if (frame_err === 1'b1) n_ferr++;
`endif

  // Drives one frame starting on a negedge; nbits<10 aborts with SS_n high
  // in the cycle the next bit would be sampled.
  task automatic send_frame(input logic [9:0] w, input int nbits, input int extra,
                            input bit keep_ss);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'($urandom);
    if (nbits == 10) rx_q.push_back('{w, cyc + 12});
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = w[9-i];
      @(negedge clk);
    end
    if (nbits == 10) begin
      repeat (extra + 1) begin
        MOSI = 1'($urandom);
        @(negedge clk);
      end
    end
    if (!keep_ss) begin
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
  endtask

  // tx_valid pulse; expect_out selects whether MISO must carry the byte
  task automatic pulse_tx(input logic [7:0] d, input bit expect_out);
    logic seen;
    tx_data  = d;
    if (expect_out) tx_q.push_back(d);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      seen = seen | MISO;
      @(negedge clk);
    end
    if (!expect_out) chk("miso_quiet_when_not_waiting", {31'h0, seen}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_miso", {31'h0, MISO}, 32'h0);
    chk("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_rx_data", {22'h0, rx_data}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // write address, write data with trailing extra bits
    send_frame(10'h03C, 10, 0, 0);
    send_frame(10'h1A5, 10, 3, 0);

    // read address, read data with tx byte, then third read goes to READ_ADD
    send_frame(10'h23C, 10, 0, 0);
    send_frame(10'h300, 10, 0, 1);
    pulse_tx(8'hA5, 1'b1);
    end_frame();
    send_frame(10'h27E, 10, 0, 1);
    pulse_tx(8'hFF, 1'b0);
    end_frame();

    // abort after 4 bits, and abort in the cycle bit 0 would be sampled
    send_frame(10'h2AA, 4, 0, 0);
    chk("abort_rx_data_held", {22'h0, rx_data}, {22'h0, 10'h27E});
    send_frame(10'h155, 9, 0, 0);
    chk("abort_at_bit0_rx_data_held", {22'h0, rx_data}, {22'h0, 10'h27E});

    // rd_addr_seen survived the aborts: read frame shifts data; abort mid-shift
    send_frame(10'h300, 10, 0, 1);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("miso_shift_bit7", {31'h0, MISO}, 32'h1);
    @(negedge clk);
    chk("miso_shift_bit6", {31'h0, MISO}, 32'h1);
    @(negedge clk);
    chk("miso_shift_bit5", {31'h0, MISO}, 32'h0);
    SS_n = 1'b1;
    @(negedge clk);
    chk("miso_zero_after_abort", {31'h0, MISO}, 32'h0);
    send_frame(10'h300, 10, 0, 1);
    pulse_tx(8'h5A, 1'b1);
    end_frame();

    // async reset mid-frame after 5 bits; next read frame is a read address
    send_frame(10'h211, 10, 0, 0);
    @(negedge clk);
    SS_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      MOSI = (i % 2 == 0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_miso", {31'h0, MISO}, 32'h0);
    chk("rst_mid_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_mid_rx_data", {22'h0, rx_data}, 32'h0);
    @(negedge clk);
    SS_n  = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(10'h3FF, 10, 0, 1);
    pulse_tx(8'hFF, 1'b0);
    end_frame();

    repeat (5) @(negedge clk);
    chk("rx_queue_drained", rx_q.size(), 32'h0);
    chk("tx_queue_drained", tx_q.size(), 32'h0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("frame_err_pulses", n_ferr, 32'd3);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
